// File: rtl/activ_stage_arbiter.sv
// Round-robin arbiter that time-shares one activation-function stage between N
// accumulator requesters, with a watchdog that aborts operations the stage never finishes.
module activ_stage_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [16*N-1:0]   req_val,
    input  logic [2*N-1:0]    req_sel,
    input  logic [16*N-1:0]   req_dest,
    output logic [N-1:0]      ack,
    output logic [15:0]       rsp_val,
    output logic [15:0]       rsp_dest,
    output logic              rsp_err,
    output logic              busy,
    output logic [15:0]       act_val,
    output logic [1:0]        act_sel,
    output logic [15:0]       act_dest,
    output logic              act_we,
    output logic              act_clr,
    input  logic [15:0]       act_result,
    input  logic              act_done
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W:0] NumReq = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StClear} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [15:0]      rsp_val_q, rsp_val_d;
    logic [15:0]      rsp_dest_q, rsp_dest_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    logic [15:0]      act_val_q, act_val_d;
    logic [1:0]       act_sel_q, act_sel_d;
    logic [15:0]      act_dest_q, act_dest_d;
    logic             act_we_q, act_we_d;
    logic             act_clr_q, act_clr_d;

    // Rotating priority scan: first set request at or above the pointer, wrapping modulo N.
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= NumReq) begin
                sum = sum - NumReq;
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        rsp_val_d  = '0;
        rsp_err_d  = 1'b0;
        rsp_dest_d = rsp_dest_q;
        act_val_d  = act_val_q;
        act_sel_d  = act_sel_q;
        act_dest_d = act_dest_q;
        act_we_d   = 1'b0;
        act_clr_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    g_d        = pick;
                    act_val_d  = req_val[int'(pick)*16 +: 16];
                    act_sel_d  = req_sel[int'(pick)*2 +: 2];
                    act_dest_d = req_dest[int'(pick)*16 +: 16];
                    act_we_d   = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done arriving on the last watchdog cycle still counts as success.
                if (act_done) begin
                    rsp_val_d  = act_result;
                    rsp_dest_d = act_dest_q;
                    ack_d      = N'(1) << g_q;
                    state_d    = StClear;
                end else if (cnt_q == CntLast) begin
                    rsp_dest_d = act_dest_q;
                    rsp_err_d  = 1'b1;
                    ack_d      = N'(1) << g_q;
                    state_d    = StClear;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StClear: begin
                act_clr_d = 1'b1;
                ptr_d     = (g_q == LastIdx) ? '0 : g_q + 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            g_q        <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rsp_val_q  <= '0;
            rsp_dest_q <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            act_val_q  <= '0;
            act_sel_q  <= '0;
            act_dest_q <= '0;
            act_we_q   <= 1'b0;
            act_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rsp_val_q  <= rsp_val_d;
            rsp_dest_q <= rsp_dest_d;
            rsp_err_q  <= rsp_err_d;
            busy_q     <= busy_d;
            act_val_q  <= act_val_d;
            act_sel_q  <= act_sel_d;
            act_dest_q <= act_dest_d;
            act_we_q   <= act_we_d;
            act_clr_q  <= act_clr_d;
        end
    end

    assign ack      = ack_q;
    assign rsp_val  = rsp_val_q;
    assign rsp_dest = rsp_dest_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = busy_q;
    assign act_val  = act_val_q;
    assign act_sel  = act_sel_q;
    assign act_dest = act_dest_q;
    assign act_we   = act_we_q;
    assign act_clr  = act_clr_q;

endmodule

// File: tb/tb_activ_stage_arbiter.sv
// Directed bench for activ_stage_arbiter: a small stage model answers act_we after a
// programmable delay (0 = never) and each scenario task checks the arbiter's outputs.
module tb_activ_stage_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [16*N-1:0] req_val;
    logic [2*N-1:0]  req_sel;
    logic [16*N-1:0] req_dest;
    logic [N-1:0]  ack;
    logic [15:0]   rsp_val;
    logic [15:0]   rsp_dest;
    logic          rsp_err;
    logic          busy;
    logic [15:0]   act_val;
    logic [1:0]    act_sel;
    logic [15:0]   act_dest;
    logic          act_we;
    logic          act_clr;
    logic [15:0]   act_result;
    logic          act_done;

    int checks = 0;
    int errors = 0;
    int done_delay = 0;
    int countdown = 0;

    activ_stage_arbiter #(.N(4), .IDX_W(2), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_val    (req_val),
        .req_sel    (req_sel),
        .req_dest   (req_dest),
        .ack        (ack),
        .rsp_val    (rsp_val),
        .rsp_dest   (rsp_dest),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .act_val    (act_val),
        .act_sel    (act_sel),
        .act_dest   (act_dest),
        .act_we     (act_we),
        .act_clr    (act_clr),
        .act_result (act_result),
        .act_done   (act_done)
    );

    always #5 clk = ~clk;

    // Stage model: done is high in the cycle done_delay cycles after the act_we cycle.
    always @(negedge clk) begin
        act_done = 1'b0;
        if (rst) begin
            countdown = 0;
        end else begin
            if (countdown > 0) begin
                countdown = countdown - 1;
                if (countdown == 0) act_done = 1'b1;
            end
            if (act_we && done_delay > 0) countdown = done_delay;
        end
    end

    task automatic set_req(input int i, input logic [15:0] v, input logic [1:0] s,
                           input logic [15:0] d);
        req_val[i*16 +: 16] = v;
        req_sel[i*2 +: 2]   = s;
        req_dest[i*16 +: 16] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns the 1-based negedge count at which ack was first seen, 0 if never within max.
    task automatic wait_ack(input int max, output int cycles);
        cycles = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        checks++;
        if ({ack, rsp_val, rsp_dest, rsp_err, busy, act_val, act_sel, act_dest, act_we,
             act_clr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b rsp_val=%h busy=%b act_we=%b expected all 0",
                     ack, rsp_val, busy, act_we);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, act_we} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b act_we=%b expected 0 0", busy, act_we);
        end
    endtask

    task automatic test_single();
        int cyc;
        do_reset();
        done_delay = 2;
        act_result = 16'h00AA;
        set_req(1, 16'h1234, 2'b01, 16'h0040);
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if ({act_we, busy, act_val, act_sel, act_dest} !== {2'b11, 16'h1234, 2'b01, 16'h0040})
        begin
            errors++;
            $display("FAIL single_issue: we=%b busy=%b val=%h sel=%b dest=%h expected 1 1 1234 01 0040",
                     act_we, busy, act_val, act_sel, act_dest);
        end
        @(negedge clk);
        checks++;
        if (act_we !== 1'b0) begin
            errors++;
            $display("FAIL single_we_pulse: act_we=%b expected 0", act_we);
        end
        wait_ack(20, cyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL single_ack_latency: got %0d expected 2", cyc);
        end
        checks++;
        if ({ack, rsp_val, rsp_dest, rsp_err} !== {4'b0010, 16'h00AA, 16'h0040, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: ack=%b val=%h dest=%h err=%b expected 0010 00aa 0040 0",
                     ack, rsp_val, rsp_dest, rsp_err);
        end
        checks++;
        if (act_val !== 16'h1234) begin
            errors++;
            $display("FAIL single_val_stable: act_val=%h expected 1234", act_val);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if ({act_clr, ack, rsp_val, rsp_err, busy} !== {1'b1, 4'b0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_clear: clr=%b ack=%b val=%h err=%b busy=%b expected 1 0 0 0 0",
                     act_clr, ack, rsp_val, rsp_err, busy);
        end
        @(negedge clk);
        checks++;
        if (act_clr !== 1'b0) begin
            errors++;
            $display("FAIL single_clr_pulse: act_clr=%b expected 0", act_clr);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        logic [3:0] exp_ack;
        do_reset();
        done_delay = 1;
        act_result = 16'h5555;
        for (int i = 0; i < N; i++) begin
            set_req(i, 16'h1000 + 16'(i), 2'(i), 16'h0100 + 16'(i));
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_ack = 4'b0001 << (k % 4);
            wait_ack(10, cyc);
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL rr_grant_%0d: ack=%b expected %b", k, ack, exp_ack);
            end
            checks++;
            if ({rsp_dest, act_val} !== {16'h0100 + 16'(k % 4), 16'h1000 + 16'(k % 4)}) begin
                errors++;
                $display("FAIL rr_data_%0d: dest=%h val=%h expected %h %h", k, rsp_dest,
                         act_val, 16'h0100 + 16'(k % 4), 16'h1000 + 16'(k % 4));
            end
            @(negedge clk);
            checks++;
            if ({ack, act_clr} !== {4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL rr_ack_width_%0d: ack=%b clr=%b expected 0000 1", k, ack, act_clr);
            end
        end
        req = '0;
    endtask

    task automatic test_wrap();
        int cyc;
        do_reset();
        done_delay = 1;
        req = 4'b1000;
        wait_ack(10, cyc);
        checks++;
        if (ack !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: ack=%b expected 1000", ack);
        end
        req = 4'b1001;
        wait_ack(10, cyc);
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_to_zero: ack=%b expected 0001", ack);
        end
        wait_ack(10, cyc);
        checks++;
        if (ack !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_then_three: ack=%b expected 1000", ack);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset();
        done_delay = 0;
        act_result = 16'hFFFF;
        set_req(0, 16'h0F0F, 2'b10, 16'h0ABC);
        req = 4'b0001;
        wait_ack(40, cyc);
        checks++;
        if (cyc !== 18) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected 18", cyc);
        end
        checks++;
        if ({ack, rsp_err, rsp_val, rsp_dest} !== {4'b0001, 1'b1, 16'h0000, 16'h0ABC}) begin
            errors++;
            $display("FAIL timeout_rsp: ack=%b err=%b val=%h dest=%h expected 0001 1 0000 0abc",
                     ack, rsp_err, rsp_val, rsp_dest);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if ({act_clr, busy, rsp_err} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_clear: clr=%b busy=%b err=%b expected 1 0 0",
                     act_clr, busy, rsp_err);
        end
    endtask

    task automatic test_collide();
        int cyc;
        do_reset();
        done_delay = 16;
        act_result = 16'hBEEF;
        set_req(2, 16'h2222, 2'b11, 16'h0777);
        req = 4'b0100;
        wait_ack(40, cyc);
        checks++;
        if (cyc !== 18) begin
            errors++;
            $display("FAIL collide_latency: got %0d expected 18", cyc);
        end
        checks++;
        if ({ack, rsp_err, rsp_val, rsp_dest} !== {4'b0100, 1'b0, 16'hBEEF, 16'h0777}) begin
            errors++;
            $display("FAIL collide_rsp: ack=%b err=%b val=%h dest=%h expected 0100 0 beef 0777",
                     ack, rsp_err, rsp_val, rsp_dest);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        do_reset();
        done_delay = 0;
        set_req(2, 16'h3C3C, 2'b01, 16'h0123);
        req = 4'b0100;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: busy=%b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ack, rsp_val, rsp_dest, rsp_err, busy, act_val, act_sel, act_dest, act_we,
             act_clr} !== '0) begin
            errors++;
            $display("FAIL midrst_async: ack=%b busy=%b act_val=%h act_dest=%h expected all 0",
                     ack, busy, act_val, act_dest);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_no_ack: ack=%b expected 0000", ack);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({act_we, act_val, act_dest} !== {1'b1, 16'h3C3C, 16'h0123}) begin
            errors++;
            $display("FAIL midrst_regrant: we=%b val=%h dest=%h expected 1 3c3c 0123",
                     act_we, act_val, act_dest);
        end
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        req_val    = '0;
        req_sel    = '0;
        req_dest   = '0;
        act_result = '0;
        act_done   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_collide();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
